// File: rtl/ps2_dec_pkg.sv
// ps2_dec_pkg: shared types and constants for the PS/2 key decoder.
//   frame_state_e : receive frame FSM states
//   SCAN_*        : scan codes with special meaning (prefixes, Enter, Esc)
//   key_entry_t   : one decoded-key queue entry {code, brk, ext}
package ps2_dec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_e;

  localparam logic [7:0] SCAN_EXT   = 8'hE0;
  localparam logic [7:0] SCAN_BRK   = 8'hF0;
  localparam logic [7:0] SCAN_ENTER = 8'h5A;
  localparam logic [7:0] SCAN_ESC   = 8'h76;

  typedef struct packed {
    logic [6:0] code;
    logic       brk;
    logic       ext;
  } key_entry_t;

endpackage

// File: rtl/ps2_scan_table.sv
// ps2_scan_table: combinational scan-code translation.
//   scan_i : 8-bit set-2 scan code
//   ext_i  : scan code was preceded by the E0 prefix
//   code_o : 7-bit translated key code (0 when not mapped)
//   hit_o  : scan code is mapped
module ps2_scan_table
  import ps2_dec_pkg::*;
(
  input  logic [7:0] scan_i,
  input  logic       ext_i,
  output logic [6:0] code_o,
  output logic       hit_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    code_o = '0;
    hit_o  = 1'b1;
    if (ext_i) begin
      case (scan_i)
        8'h75:      code_o = 7'h11;  // up
        8'h72:      code_o = 7'h12;  // down
        8'h6B:      code_o = 7'h13;  // left
        8'h74:      code_o = 7'h14;  // right
        SCAN_ENTER: code_o = 7'h0D;  // keypad enter
        default:    hit_o  = 1'b0;
      endcase
    end else begin
      case (scan_i)
        8'h1C:      code_o = 7'h41;  // A
        8'h32:      code_o = 7'h42;  // B
        8'h21:      code_o = 7'h43;  // C
        8'h23:      code_o = 7'h44;  // D
        8'h24:      code_o = 7'h45;  // E
        8'h2B:      code_o = 7'h46;  // F
        8'h34:      code_o = 7'h47;  // G
        8'h33:      code_o = 7'h48;  // H
        8'h43:      code_o = 7'h49;  // I
        8'h3B:      code_o = 7'h4A;  // J
        8'h45:      code_o = 7'h30;  // 0
        8'h16:      code_o = 7'h31;  // 1
        8'h1E:      code_o = 7'h32;  // 2
        8'h26:      code_o = 7'h33;  // 3
        8'h29:      code_o = 7'h20;  // space
        8'h66:      code_o = 7'h08;  // backspace
        SCAN_ENTER: code_o = 7'h0D;  // enter
        SCAN_ESC:   code_o = 7'h1B;  // escape
        default:    hit_o  = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver, prefix handling, translation and
// a first-word-fall-through queue of decoded keys.
//   clk_i, reset_ni    : system clock, asynchronous active-low reset
//   ps2d_i, ps2c_i     : raw PS/2 data/clock (asynchronous)
//   rx_en_i            : receive enable; low aborts any frame in progress
//   rd_en_i            : pop the queue head
//   valid_o            : queue not empty; code_o/is_break_o/is_ext_o meaningful
//   code_o             : translated key code at queue head
//   is_break_o/is_ext_o: head entry is a release / carried an E0 prefix
//   iniciar_o/terminar_o: one-cycle pulses for Enter make / Esc make
//   frame_err_o        : one-cycle pulse on parity/stop error or timeout
//   overflow_o         : one-cycle pulse when a key is dropped on a full queue
//   fifo_count_o       : queue occupancy 0..FIFO_DEPTH
// Build option: define PS2_BREAK_EN to queue break codes with is_break_o=1;
// otherwise break codes are consumed and is_break_o stays 0.
module ps2_key_decoder
  import ps2_dec_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          ps2d_i,
  input  logic                          ps2c_i,
  input  logic                          rx_en_i,
  input  logic                          rd_en_i,
  output logic                          valid_o,
  output logic [6:0]                    code_o,
  output logic                          is_break_o,
  output logic                          is_ext_o,
  output logic                          iniciar_o,
  output logic                          terminar_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

`ifdef PS2_BREAK_EN
  localparam logic BREAK_EN = 1'b1;
`else
  localparam logic BREAK_EN = 1'b0;
`endif

  // ---------------- synchroniser and clock filter ----------------
  logic             c_s1_q, c_s2_q, d_s1_q, d_s2_q, c_flt_q;
  logic [FLT_W-1:0] flt_cnt_q;
  logic             flt_accept_w, fall_w;

  // The filtered clock flips in the FILTER_LEN-th consecutive cycle that the
  // synchronised clock disagrees with it; the falling edge is that flip to 0.
  assign flt_accept_w = (c_s2_q != c_flt_q) && (flt_cnt_q == FLT_W'(FILTER_LEN - 1));
  assign fall_w       = flt_accept_w && !c_s2_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      c_s1_q    <= 1'b1;
      c_s2_q    <= 1'b1;
      d_s1_q    <= 1'b1;
      d_s2_q    <= 1'b1;
      c_flt_q   <= 1'b1;
      flt_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep the two flop stages distinct.
      c_s1_q <= ps2c_i;
      c_s2_q <= c_s1_q;
      d_s1_q <= ps2d_i;
      d_s2_q <= d_s1_q;
      if (c_s2_q == c_flt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_accept_w) begin
        c_flt_q   <= c_s2_q;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FLT_W'(1);
      end
    end
  end

  // ---------------- frame FSM ----------------
  frame_state_e     state_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q, byte_q;
  logic             par_q, byte_valid_q, frame_err_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_hit_w;

  assign tmo_hit_w = rx_en_i && (state_q != IDLE) && !fall_w &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_cnt_q    <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (!rx_en_i) begin
        state_q   <= IDLE;
        tmo_cnt_q <= '0;
      end else if (tmo_hit_w) begin
        state_q     <= IDLE;
        tmo_cnt_q   <= '0;
        frame_err_q <= 1'b1;
      end else begin
        tmo_cnt_q <= (fall_w || state_q == IDLE) ? '0 : tmo_cnt_q + TMO_W'(1);
        if (fall_w) begin
          case (state_q)
            IDLE: begin
              if (!d_s2_q) begin
                state_q   <= DATA;
                bit_cnt_q <= '0;
                par_q     <= 1'b0;
              end
            end
            DATA: begin
              shift_q   <= {d_s2_q, shift_q[7:1]};
              par_q     <= par_q ^ d_s2_q;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= PARITY;
            end
            PARITY: begin
              par_q   <= par_q ^ d_s2_q;
              state_q <= STOP;
            end
            STOP: begin
              state_q <= IDLE;
              // par_q is the XOR of data and parity bits: odd parity means 1.
              if (par_q && d_s2_q) begin
                byte_q       <= shift_q;
                byte_valid_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  // ---------------- prefix handling and translation ----------------
  logic       ext_q, brk_q, is_prefix_w, tbl_hit_w, push_w, make_w;
  logic [6:0] tbl_code_w;
  key_entry_t entry_w;

  ps2_scan_table u_scan_table (
    .scan_i (byte_q),
    .ext_i  (ext_q),
    .code_o (tbl_code_w),
    .hit_o  (tbl_hit_w)
  );

  assign is_prefix_w = (byte_q == SCAN_EXT) || (byte_q == SCAN_BRK);
  assign push_w      = byte_valid_q && !is_prefix_w && tbl_hit_w && (!brk_q || BREAK_EN);
  assign make_w      = byte_valid_q && !is_prefix_w && tbl_hit_w && !brk_q;

  always_comb begin
    entry_w      = '0;
    entry_w.code = tbl_code_w;
    entry_w.brk  = brk_q & BREAK_EN;
    entry_w.ext  = ext_q;
  end

  // ---------------- queue ----------------
  key_entry_t       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_w, pop_w, wr_w;
  logic             iniciar_q, terminar_q, overflow_q;
  key_entry_t       head_w;

  assign full_w = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
  assign pop_w  = rd_en_i && (count_q != '0);
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign wr_w   = push_w && (!full_w || pop_w);

  always_comb begin
    count_d = count_q;
    if (wr_w && !pop_w)      count_d = count_q + (PTR_W + 1)'(1);
    else if (!wr_w && pop_w) count_d = count_q - (PTR_W + 1)'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      iniciar_q  <= 1'b0;
      terminar_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (tmo_hit_w) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (byte_valid_q) begin
        if (byte_q == SCAN_EXT) begin
          ext_q <= 1'b1;
        end else if (byte_q == SCAN_BRK) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
      if (wr_w)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_w) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      iniciar_q  <= make_w && (byte_q == SCAN_ENTER);
      terminar_q <= make_w && (byte_q == SCAN_ESC);
      overflow_q <= push_w && full_w && !pop_w;
    end
  end

  // NOTE: storage is not reset; outputs are gated by valid_o instead.
  always_ff @(posedge clk_i) begin
    if (wr_w) mem_q[wr_ptr_q] <= entry_w;
  end

  assign head_w       = mem_q[rd_ptr_q];
  assign valid_o      = (count_q != '0);
  assign code_o       = valid_o ? head_w.code : '0;
  assign is_break_o   = valid_o & head_w.brk;
  assign is_ext_o     = valid_o & head_w.ext;
  assign iniciar_o    = iniciar_q;
  assign terminar_o   = terminar_q;
  assign frame_err_o  = frame_err_q;
  assign overflow_o   = overflow_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed PS/2 frames against a transaction-level model
// (queue of expected entries plus expected pulses), compared every cycle.
module tb_ps2_key_decoder;

  localparam int DEPTH = 8;
  localparam int FLT   = 8;
  localparam int TMO   = 300;
  localparam int H     = 20;  // PS/2 half bit period in clk cycles

`ifdef PS2_BREAK_EN
  localparam bit BREAK_EN = 1'b1;
`else
  localparam bit BREAK_EN = 1'b0;
`endif

  logic       clk, reset_n, ps2d, ps2c, rx_en, rd_en;
  logic       valid, is_break, is_ext, iniciar, terminar, frame_err, overflow;
  logic [6:0] code;
  logic [3:0] fifo_count;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLT), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk), .reset_ni(reset_n), .ps2d_i(ps2d), .ps2c_i(ps2c),
    .rx_en_i(rx_en), .rd_en_i(rd_en), .valid_o(valid), .code_o(code),
    .is_break_o(is_break), .is_ext_o(is_ext), .iniciar_o(iniciar),
    .terminar_o(terminar), .frame_err_o(frame_err), .overflow_o(overflow),
    .fifo_count_o(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] code;
    logic       brk;
    logic       ext;
  } ent_t;

  int checks = 0, errors = 0;
  int n_ini = 0, n_ter = 0, n_ferr = 0, n_ovf = 0;

  ent_t       mq[$];
  logic [6:0] key_map [logic [8:0]];
  bit         m_ext, m_brk, e_ini, e_ter, e_ovf, e_ferr, err_dc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected behaviour of one good byte arriving, applied at the push edge.
  task automatic model_byte(input logic [7:0] b, input bit pop);
    bit   full, popped, hit;
    ent_t e;
    full   = (mq.size() == DEPTH);
    popped = pop && (mq.size() != 0);
    if (popped) void'(mq.pop_front());
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      hit = key_map.exists({m_ext, b});
      if (hit && (!m_brk || BREAK_EN)) begin
        if (full && !popped) e_ovf = 1'b1;
        else begin
          e.code = key_map[{m_ext, b}];
          e.brk  = m_brk;
          e.ext  = m_ext;
          mq.push_back(e);
        end
      end
      if (hit && !m_brk) begin
        e_ini = (b == 8'h5A);
        e_ter = (b == 8'h76);
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // Full 11-bit frame. The stop bit's ps2c fall is accepted FLT+2 edges after
  // it is driven (2 sync + FLT filter); the push lands one edge later.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit pop_at_push);
    logic [10:0] bits;
    bit          bad;
    bits = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
    bad  = bad_par || bad_stop;
    for (int i = 0; i < 10; i++) begin
      ps2d = bits[i];
      wait_cyc(H); ps2c = 1'b0;
      wait_cyc(H); ps2c = 1'b1;
    end
    ps2d = bits[10];
    wait_cyc(H); ps2c = 1'b0;
    wait_cyc(FLT + 2);
    if (bad) e_ferr = 1'b1;
    if (pop_at_push) rd_en = 1'b1;
    wait_cyc(1);
    if (bad) begin
      e_ferr = 1'b0;
      if (pop_at_push && mq.size() != 0) void'(mq.pop_front());
    end else begin
      model_byte(b, pop_at_push);
    end
    rd_en = 1'b0;
    wait_cyc(1);
    e_ini = 1'b0; e_ter = 1'b0; e_ovf = 1'b0;
    wait_cyc(H - FLT - 4); ps2c = 1'b1;
    wait_cyc(H);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0);
  endtask

  // Start bit plus the first n data bits, then the clock stops high.
  task automatic send_partial(input logic [7:0] b, input int n);
    logic [8:0] bits;
    bits = {b, 1'b0};
    for (int i = 0; i <= n; i++) begin
      ps2d = bits[i];
      wait_cyc(H); ps2c = 1'b0;
      wait_cyc(H); ps2c = 1'b1;
    end
    ps2d = 1'b1;
    wait_cyc(H);
  endtask

  task automatic do_pop();
    rd_en = 1'b1;
    wait_cyc(1);
    if (mq.size() != 0) void'(mq.pop_front());
    rd_en = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ext = 1'b0; m_brk = 1'b0;
    e_ini = 1'b0; e_ter = 1'b0; e_ovf = 1'b0; e_ferr = 1'b0;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  ent_t cmp_h;
  bit   cmp_v;
  always @(negedge clk) begin
    cmp_v = (mq.size() != 0);
    cmp_h = cmp_v ? mq[0] : '0;
    check("valid", 32'(valid), 32'(cmp_v));
    check("code", 32'(code), 32'(cmp_h.code));
    check("is_break", 32'(is_break), 32'(cmp_h.brk));
    check("is_ext", 32'(is_ext), 32'(cmp_h.ext));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("iniciar", 32'(iniciar), 32'(e_ini));
    check("terminar", 32'(terminar), 32'(e_ter));
    check("overflow", 32'(overflow), 32'(e_ovf));
    if (!err_dc) check("frame_err", 32'(frame_err), 32'(e_ferr));
    if (iniciar)   n_ini++;
    if (terminar)  n_ter++;
    if (frame_err) n_ferr++;
    if (overflow)  n_ovf++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, t0;
    key_map[{1'b0, 8'h1C}] = 7'h41; key_map[{1'b0, 8'h32}] = 7'h42;
    key_map[{1'b0, 8'h21}] = 7'h43; key_map[{1'b0, 8'h23}] = 7'h44;
    key_map[{1'b0, 8'h24}] = 7'h45; key_map[{1'b0, 8'h2B}] = 7'h46;
    key_map[{1'b0, 8'h34}] = 7'h47; key_map[{1'b0, 8'h33}] = 7'h48;
    key_map[{1'b0, 8'h43}] = 7'h49; key_map[{1'b0, 8'h3B}] = 7'h4A;
    key_map[{1'b0, 8'h45}] = 7'h30; key_map[{1'b0, 8'h16}] = 7'h31;
    key_map[{1'b0, 8'h1E}] = 7'h32; key_map[{1'b0, 8'h26}] = 7'h33;
    key_map[{1'b0, 8'h29}] = 7'h20; key_map[{1'b0, 8'h66}] = 7'h08;
    key_map[{1'b0, 8'h5A}] = 7'h0D; key_map[{1'b0, 8'h76}] = 7'h1B;
    key_map[{1'b1, 8'h75}] = 7'h11; key_map[{1'b1, 8'h72}] = 7'h12;
    key_map[{1'b1, 8'h6B}] = 7'h13; key_map[{1'b1, 8'h74}] = 7'h14;
    key_map[{1'b1, 8'h5A}] = 7'h0D;
    err_dc = 1'b0;
    model_reset();
    reset_n = 1'b0; ps2d = 1'b1; ps2c = 1'b1; rx_en = 1'b1; rd_en = 1'b0;
    wait_cyc(3);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    reset_n = 1'b1;
    wait_cyc(H);

    // Single make code 'A'.
    send_good(8'h1C);
    check("a_code", 32'(code), 32'h41);
    check("a_count", 32'(fifo_count), 32'd1);
    check("a_break", 32'(is_break), 32'd0);
    do_pop();

    // Break prefix, then a break of Enter must not start anything.
    n0 = n_ini;
    send_good(8'hF0); send_good(8'h1C);
    check("brk_count", 32'(fifo_count), BREAK_EN ? 32'd1 : 32'd0);
    if (BREAK_EN) check("brk_flag", 32'(is_break), 32'd1);
    send_good(8'hF0); send_good(8'h5A);
    check("brk_no_ini", 32'(n_ini - n0), 32'd0);
    while (mq.size() != 0) do_pop();

    // Extended key.
    send_good(8'hE0); send_good(8'h75);
    check("ext_code", 32'(code), 32'h11);
    check("ext_flag", 32'(is_ext), 32'd1);
    do_pop();

    // Bad parity, bad stop, then good Enter.
    n0 = n_ferr; t0 = n_ini;
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check("perr_pulses", 32'(n_ferr - n0), 32'd2);
    check("perr_count", 32'(fifo_count), 32'd0);
    check("perr_no_ini", 32'(n_ini - t0), 32'd0);
    send_good(8'h5A);
    check("enter_ini", 32'(n_ini - t0), 32'd1);
    check("enter_count", 32'(fifo_count), 32'd1);
    do_pop();

    // Unmapped code drops silently and clears a pending break prefix.
    send_good(8'hF0); send_good(8'h0E); send_good(8'h1C);
    check("unmap_count", 32'(fifo_count), 32'd1);
    check("unmap_make", 32'(is_break), 32'd0);
    do_pop();

    // Fill past capacity; Esc as the dropped ninth still pulses terminar.
    n0 = n_ovf; t0 = n_ter;
    foreach (key_map[k]) if (k == 9'h000) check("never", 32'd0, 32'd1);
    send_good(8'h1C); send_good(8'h32); send_good(8'h21); send_good(8'h23);
    send_good(8'h24); send_good(8'h2B); send_good(8'h34); send_good(8'h33);
    send_good(8'h76);
    check("full_count", 32'(fifo_count), 32'd8);
    check("ovf_pulse", 32'(n_ovf - n0), 32'd1);
    check("ovf_ter", 32'(n_ter - t0), 32'd1);
    check("full_head", 32'(code), 32'h41);
    send_frame(8'h43, 1'b0, 1'b0, 1'b1);
    check("pp_count", 32'(fifo_count), 32'd8);
    check("pp_no_ovf", 32'(n_ovf - n0), 32'd1);
    check("pp_head", 32'(code), 32'h42);
    repeat (8) do_pop();
    check("drain_count", 32'(fifo_count), 32'd0);

    // Timeout after 4 data bits also clears a pending E0.
    send_good(8'hE0);
    send_partial(8'h1C, 4);
    err_dc = 1'b1;
    n0 = n_ferr;
    wait_cyc(TMO - 60);
    check("tmo_early", 32'(n_ferr - n0), 32'd0);
    wait_cyc(100);
    check("tmo_pulse", 32'(n_ferr - n0), 32'd1);
    m_ext = 1'b0; m_brk = 1'b0;
    err_dc = 1'b0;
    send_good(8'h1C);
    check("tmo_next", 32'(code), 32'h41);
    check("tmo_noext", 32'(is_ext), 32'd0);

    // rx_en low mid-frame; reads still work.
    send_partial(8'hFF, 3);
    rx_en = 1'b0;
    wait_cyc(5);
    do_pop();
    wait_cyc(20);
    rx_en = 1'b1;
    wait_cyc(H);
    send_good(8'h16);
    check("rxen_code", 32'(code), 32'h31);
    check("rxen_count", 32'(fifo_count), 32'd1);

    // Reset mid-frame with three entries queued.
    send_good(8'h24); send_good(8'h2B);
    check("pre_rst_count", 32'(fifo_count), 32'd3);
    send_partial(8'h55, 3);
    reset_n = 1'b0;
    model_reset();
    wait_cyc(2);
    check("mrst_valid", 32'(valid), 32'd0);
    check("mrst_count", 32'(fifo_count), 32'd0);
    check("mrst_code", 32'(code), 32'd0);
    reset_n = 1'b1;
    wait_cyc(H);
    t0 = n_ter;
    send_good(8'h76);
    check("esc_ter", 32'(n_ter - t0), 32'd1);
    check("esc_count", 32'(fifo_count), 32'd1);
    check("esc_code", 32'(code), 32'h1B);

    // Pop on empty is ignored.
    do_pop(); do_pop();
    check("empty_pop", 32'(fifo_count), 32'd0);

    wait_cyc(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, decoded-key queue depth; power of two, minimum 2.
REQ-002 Parameter FILTER_LEN, default 8, clk cycles ps2c must stay stable before a level change is accepted.
REQ-003 Parameter TIMEOUT_CYC, default 5000, maximum clk cycles between ps2c falling edges inside a frame.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 ps2d, ps2c  input  1 each  raw PS/2 data and clock, asynchronous to clk.
REQ-007 rx_en  input  1  receive enable.
REQ-008 rd_en  input  1  pop request for the queue head.
REQ-009 valid  output  1  queue not empty; head fields are meaningful.
REQ-010 code  output  7  translated key code at queue head.
REQ-011 is_break, is_ext  output  1 each  head entry is a release / carried E0 prefix.
REQ-012 iniciar, terminar  output  1 each  one-cycle pulses for Enter make / Esc make.
REQ-013 frame_err, overflow  output  1 each  one-cycle error pulses.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  current queue occupancy.

Function
REQ-015 ps2c, ps2d double-flop synchronised; ps2c filtered per FILTER_LEN; falling edge = filtered 1->0.
REQ-016 Frame FSM states IDLE, DATA, PARITY, STOP; one bit sampled per falling edge.
REQ-017 IDLE->DATA on falling edge with ps2d=0; start bit 1 stays IDLE, no error.
REQ-018 DATA shifts 8 bits LSB first, then PARITY (odd parity over data+parity), then STOP (must be 1), then IDLE.
REQ-019 Parity or stop failure: byte discarded, frame_err pulses 1 cycle, FSM to IDLE.
REQ-020 Non-IDLE with no falling edge for TIMEOUT_CYC cycles: abort to IDLE, frame_err pulse, prefix flags cleared.
REQ-021 rx_en low: FSM forced IDLE, frame in progress discarded silently; queue contents and reads unaffected.
REQ-022 Byte 0xE0 sets ext flag, 0xF0 sets brk flag; neither is queued; both clear after the next non-prefix byte.
REQ-023 Non-prefix byte translated by lookup; unmapped scan codes dropped, flags cleared, nothing queued.
REQ-024 Mapped entry {code, brk, ext} pushed exactly 1 clk after the cycle the stop bit is accepted.
REQ-025 iniciar pulses in push cycle for 0x5A make; terminar for 0x76 make; never for break codes.
REQ-026 Queue first-word-fall-through; rd_en with valid=1 pops next cycle; rd_en with valid=0 ignored.
REQ-027 Push when full and no pop: entry dropped, overflow pulses 1 cycle, iniciar/terminar still pulse.
REQ-028 Simultaneous push and pop when full: both performed, fifo_count unchanged, no overflow.
REQ-029 Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.

Reset
REQ-030 Reset asserted: FSM IDLE, filters/synchronisers to 1, flags clear, queue empty.
REQ-031 Reset values: valid=0, code=0, is_break=0, is_ext=0, iniciar=0, terminar=0, frame_err=0, overflow=0, fifo_count=0.
REQ-032 Reset mid-frame discards the partial byte; first falling edge after release treated as possible start bit.

Configuration
REQ-033 Macro PS2_BREAK_EN defined: break codes queued with is_break=1.
REQ-034 PS2_BREAK_EN undefined: break codes consumed (flags cleared, not queued) and is_break tied 0.

Structure
REQ-035 Package ps2_dec_pkg holds FSM state typedef, scan constants 0xE0, 0xF0, 0x5A, 0x76, and queue entry struct.
REQ-036 Translation table in sub-module ps2_scan_table: combinational, 8-bit scan + ext in, 7-bit code + hit out.

Verification
REQ-037 Frame 0x1C (A), good parity -> one entry code=map(0x1C), is_break=0, fifo_count=1 one cycle after stop.
REQ-038 0xF0 then 0x1C -> single entry is_break=1 (macro defined); nothing queued (macro undefined).
REQ-039 Frame 0x5A with wrong parity -> frame_err pulse, nothing queued, no iniciar; then good 0x5A -> iniciar pulse, one entry.
REQ-040 Nine make codes with FIFO_DEPTH=8 and no reads -> fifo_count=8, overflow pulse on ninth; then 8 pops drain in order.
REQ-041 Stop toggling ps2c after 4 data bits -> frame_err at TIMEOUT_CYC, FSM IDLE, next full frame decoded correctly.
REQ-042 Assert reset mid-frame with 3 queued entries -> all outputs at reset values; subsequent frame 0x76 -> terminar pulse, fifo_count=1.
